// File: rtl/fpall_pkg.sv
// Shared types and constants for the fpall issue path.
// The FP unit latency lives here so the controller and unit agree on it.
package fpall_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    BF16 = 2'd2,
    FP8  = 2'd3
  } fp_fmt_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MIN = 2'd3
  } fp_op_e;

  localparam int FPALL_LAT = 2;

endpackage

// File: rtl/fpall_issue_ctrl_if.sv
// Request, operand, result-capture and response signals of the issue controller.
// master = requester/unit side, slave = the controller.
interface fpall_issue_ctrl_if #(
  parameter int TAG_W = 4
) ();
  import fpall_pkg::*;

  logic             req_valid;
  logic             req_ready;
  fp_fmt_e          req_fmt;
  fp_op_e           req_opcode;
  logic [31:0]      req_x;
  logic [31:0]      req_y;
  logic [TAG_W-1:0] req_tag;

  fp_fmt_e          fmt_out;
  fp_op_e           opcode_out;
  logic [31:0]      X_out;
  logic [31:0]      Y_out;
  logic [31:0]      R_in;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  fp_fmt_e          res_fmt;

  modport master (
    output req_valid, req_fmt, req_opcode, req_x, req_y, req_tag, res_ready, R_in,
    input  req_ready, fmt_out, opcode_out, X_out, Y_out, res_valid, res_data, res_tag, res_fmt
  );

  modport slave (
    input  req_valid, req_fmt, req_opcode, req_x, req_y, req_tag, res_ready, R_in,
    output req_ready, fmt_out, opcode_out, X_out, Y_out, res_valid, res_data, res_tag, res_fmt
  );

endinterface

// File: rtl/fpall_result_fifo.sv
// First-word-fall-through result buffer with explicit occupancy counter.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module fpall_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop_i)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage needs no reset: the head is only meaningful while count_q != 0.
  always_ff @(posedge clk) begin
    if (push_i)
      mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop_i && count_q == '0));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/fpall_issue_ctrl.sv
// Issues operands to a fixed-latency FP unit and captures its results in order.
// Credit-based ready guarantees every in-flight op has a reserved FIFO slot.
module fpall_issue_ctrl
  import fpall_pkg::*;
#(
  parameter int LAT   = FPALL_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  fpall_issue_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FMT_W = $bits(fp_fmt_e);
  localparam int PAY_W = 32 + TAG_W + FMT_W;

  if (LAT < 1 || DEPTH < LAT + 2) begin : g_param_chk
    $error("fpall_issue_ctrl: need LAT >= 1 and DEPTH >= LAT+2");
  end

  logic             ready_q;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] occ, occ_d;
  logic             accept, push, pop, res_vld;

  logic [LAT:0]     trk_vld_q;
  logic [TAG_W-1:0] trk_tag_q [LAT+1];
  fp_fmt_e          trk_fmt_q [LAT+1];

  fp_fmt_e          fmt_q;
  fp_op_e           op_q;
  logic [31:0]      x_q, y_q;
  logic [PAY_W-1:0] head;

  assign accept = bus.req_valid & ready_q;
  assign push   = trk_vld_q[LAT];
  assign pop    = res_vld & bus.res_ready;

  always_comb begin
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(push);
    occ_d      = occ + CNT_W'(push) - CNT_W'(pop);
  end

  // Ready is the registered form of the next-cycle credit check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      inflight_q <= '0;
      fmt_q      <= FP32;
      op_q       <= OP_ADD;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      ready_q    <= ((CNT_W+1)'(inflight_d) + (CNT_W+1)'(occ_d)) < (CNT_W+1)'(DEPTH);
      inflight_q <= inflight_d;
      if (accept) begin
        fmt_q <= bus.req_fmt;
        op_q  <= bus.req_opcode;
        x_q   <= bus.req_x;
        y_q   <= bus.req_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_vld_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        trk_tag_q[i] <= '0;
        trk_fmt_q[i] <= FP32;
      end
    end else begin
      trk_vld_q    <= {trk_vld_q[LAT-1:0], accept};
      trk_tag_q[0] <= bus.req_tag;
      trk_fmt_q[0] <= bus.req_fmt;
      for (int i = 1; i <= LAT; i++) begin
        trk_tag_q[i] <= trk_tag_q[i-1];
        trk_fmt_q[i] <= trk_fmt_q[i-1];
      end
    end
  end

  fpall_result_fifo #(
    .DEPTH (DEPTH),
    .W     (PAY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({bus.R_in, trk_tag_q[LAT], trk_fmt_q[LAT]}),
    .pop_i   (pop),
    .valid_o (res_vld),
    .data_o  (head),
    .count_o (occ)
  );

  assign bus.req_ready  = ready_q;
  assign bus.fmt_out    = fmt_q;
  assign bus.opcode_out = op_q;
  assign bus.X_out      = x_q;
  assign bus.Y_out      = y_q;
  assign bus.res_valid  = res_vld;
  assign bus.res_data   = head[PAY_W-1 -: 32];
  assign bus.res_tag    = head[FMT_W +: TAG_W];
  assign bus.res_fmt    = fp_fmt_e'(head[FMT_W-1:0]);

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// Bench for fpall_issue_ctrl: models a 2-cycle FP unit and scoreboards results.
// Table vectors for single ops, hand sequences for backpressure and reset.
module tb_fpall_issue_ctrl;
  import fpall_pkg::*;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = FPALL_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpall_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpall_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // IEEE single <-> double, round to nearest even; operands kept normal.
  function automatic real f2d(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return $bitstoreal({b[31], 63'd0});
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [30:0] em;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e  = d[62:52] - 11'd896;
    em = {e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) em = em + 31'd1;
    return {d[63], em};
  endfunction

  function automatic logic [31:0] fpu(input fp_op_e op, input logic [31:0] a, input logic [31:0] b);
    real ra, rb, r;
    ra = f2d(a);
    rb = f2d(b);
    case (op)
      OP_SUB:  r = ra - rb;
      OP_MUL:  r = ra * rb;
      default: r = ra + rb;
    endcase
    return d2f(r);
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1 <= fpu(bus.opcode_out, bus.X_out, bus.Y_out);
    p2 <= p1;
  end
  assign bus.R_in = p2;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    fp_fmt_e          fmt;
  } exp_t;

  exp_t exp_q[$];
  int   n_acc = 0;
  int   n_res = 0;

  // Handshakes are evaluated at negedge for the upcoming posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        n_res++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got result tag %0h expected none", bus.res_tag);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 64'(bus.res_data), 64'(e.data));
          check("sb_tag", 64'(bus.res_tag), 64'(e.tag));
          check("sb_fmt", 64'(bus.res_fmt), 64'(e.fmt));
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        n_acc++;
        e.data = fpu(bus.req_opcode, bus.req_x, bus.req_y);
        e.tag  = bus.req_tag;
        e.fmt  = bus.req_fmt;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fp_fmt_e f, input fp_op_e o, input logic [31:0] x,
                       input logic [31:0] y, input logic [TAG_W-1:0] t);
    bus.req_valid  = 1'b1;
    bus.req_fmt    = f;
    bus.req_opcode = o;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_tag    = t;
  endtask

  // Holds the request until the edge that accepts it; leaves req_valid high.
  task automatic send(input fp_fmt_e f, input fp_op_e o, input logic [31:0] x,
                      input logic [31:0] y, input logic [TAG_W-1:0] t);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    drive(f, o, x, y, t);
    while (!done && guard < 50) begin
      if (bus.req_ready) done = 1'b1;
      tick();
      guard++;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL send_timeout: got no accept for tag %0h expected accept within 50 cycles", t);
    end
  endtask

  typedef struct {
    fp_fmt_e          fmt;
    fp_op_e           op;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_r;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, next, pops, pops_at_acc, seen, cnt, cyc, acc0, res0;

    vecs[0] = '{FP32, OP_ADD, 32'h3F800000, 32'h40000000, 4'd1,  32'h40400000};
    vecs[1] = '{FP16, OP_ADD, 32'h40400000, 32'h3F800000, 4'd2,  32'h40800000};
    vecs[2] = '{BF16, OP_SUB, 32'h40400000, 32'h3F800000, 4'd3,  32'h40000000};
    vecs[3] = '{FP32, OP_MUL, 32'h40000000, 32'h40400000, 4'd4,  32'h40C00000};
    vecs[4] = '{FP8,  OP_ADD, 32'hC0000000, 32'h3F800000, 4'd5,  32'hBF800000};
    vecs[5] = '{FP32, OP_ADD, 32'h41200000, 32'h41200000, 4'd15, 32'h41A00000};
    vecs[6] = '{FP32, OP_ADD, 32'h3F000000, 32'h3F000000, 4'd0,  32'h3F800000};

    bus.req_valid  = 1'b0;
    bus.req_fmt    = FP32;
    bus.req_opcode = OP_ADD;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_tag    = '0;
    bus.res_ready  = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_fmt_out", 64'(bus.fmt_out), 64'(FP32));
    check("reset_opcode_out", 64'(bus.opcode_out), 64'(OP_ADD));
    check("reset_x_out", 64'(bus.X_out), 64'd0);
    check("reset_y_out", 64'(bus.Y_out), 64'd0);
    rst = 1'b0;
    tick();
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);

    bus.res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].fmt, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].tag);
      bus.req_valid = 1'b0;
      check($sformatf("vec%0d_x_out", i), 64'(bus.X_out), 64'(vecs[i].x));
      lat = 0;
      while (!bus.res_valid && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT + 1));
      check($sformatf("vec%0d_data", i), 64'(bus.res_data), 64'(vecs[i].exp_r));
      check($sformatf("vec%0d_tag", i), 64'(bus.res_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_fmt", i), 64'(bus.res_fmt), 64'(vecs[i].fmt));
      check($sformatf("vec%0d_y_hold", i), 64'(bus.Y_out), 64'(vecs[i].y));
      repeat (2) tick();
    end

    // Backpressure: only DEPTH requests fit while results are not drained.
    bus.res_ready = 1'b0;
    next = 0;
    for (int c = 0; c < 10; c++) begin
      if (next < 5) drive(FP32, OP_ADD, rnd_fp(), rnd_fp(), TAG_W'(next));
      else bus.req_valid = 1'b0;
      if (bus.req_ready) next++;
      tick();
    end
    check("bp_accepted", 64'(next), 64'd4);
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    check("bp_res_valid", 64'(bus.res_valid), 64'd1);
    bus.res_ready = 1'b1;
    pops = 0;
    pops_at_acc = -1;
    for (int c = 0; c < 30 && pops < 5; c++) begin
      if (bus.req_valid && bus.req_ready && pops_at_acc < 0) pops_at_acc = pops;
      if (bus.res_valid) begin
        check($sformatf("bp_order%0d", pops), 64'(bus.res_tag), 64'(pops));
        pops++;
      end
      tick();
      if (pops_at_acc >= 0) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("bp_pops", 64'(pops), 64'd5);
    check("bp_tag4_accept_after_pops", 64'(pops_at_acc), 64'd1);
    repeat (3) tick();

    // Full FIFO: one pop frees a credit, then pop coincides with the new push.
    bus.res_ready = 1'b0;
    for (int t = 0; t < 4; t++) send(FP16, OP_MUL, rnd_fp(), rnd_fp(), TAG_W'(t));
    bus.req_valid = 1'b0;
    repeat (4) tick();
    check("full_req_ready", 64'(bus.req_ready), 64'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("full_ready_after_pop", 64'(bus.req_ready), 64'd1);
    send(BF16, OP_SUB, rnd_fp(), rnd_fp(), 4'd4);
    bus.req_valid = 1'b0;
    repeat (2) tick();
    check("full_ready_before_push", 64'(bus.req_ready), 64'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("full_res_valid", 64'(bus.res_valid), 64'd1);
    check("full_head_tag", 64'(bus.res_tag), 64'd2);
    bus.res_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 20 && bus.res_valid; c++) begin
      pops++;
      tick();
    end
    check("full_drain_count", 64'(pops), 64'd3);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with one result buffered and two in flight.
    bus.res_ready = 1'b0;
    send(FP32, OP_ADD, rnd_fp(), rnd_fp(), 4'd5);
    send(FP32, OP_ADD, rnd_fp(), rnd_fp(), 4'd6);
    send(FP32, OP_ADD, rnd_fp(), rnd_fp(), 4'd7);
    bus.req_valid = 1'b0;
    tick();
    check("rst_pre_res_valid", 64'(bus.res_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_res_valid_immediate", 64'(bus.res_valid), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.res_valid) seen++;
    end
    check("rst_no_stale_result", 64'(seen), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Streaming with res_ready held high.
    acc0 = n_acc;
    res0 = n_res;
    cnt  = 0;
    cyc  = 0;
    while (cnt < 100 && cyc < 1000) begin
      drive(FP32, OP_ADD, rnd_fp(), rnd_fp(), TAG_W'(cnt));
      if (bus.req_ready) cnt++;
      tick();
      cyc++;
    end
    bus.req_valid = 1'b0;
    repeat (10) tick();
    check("stream_accepts", 64'(n_acc - acc0), 64'd100);
    check("stream_results", 64'(n_res - res0), 64'd100);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random valid/ready traffic.
    acc0 = n_acc;
    res0 = n_res;
    cnt  = 0;
    cyc  = 0;
    while (cnt < 4000 && cyc < 40000) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        drive(fp_fmt_e'($urandom_range(0, 3)), fp_op_e'($urandom_range(0, 2)),
              rnd_fp(), rnd_fp(), TAG_W'(cnt));
      else
        bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) cnt++;
      tick();
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (12) tick();
    check("rand_accepts", 64'(n_acc - acc0), 64'd4000);
    check("rand_results", 64'(n_res - res0), 64'd4000);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_res_valid_idle", 64'(bus.res_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
